// File: rtl/pdl_puf_eval_ctrl.sv
// pdl_puf_eval_ctrl
// Evaluation sequencer for the PDL PUF. For each response bit the same challenge
// is launched NUM_VOTES times. After each launch the delay lines get SETTLE_CYCLES
// cycles to settle, then the XOR network output is sampled. The bit is the
// majority of those samples. The challenge steps by one between bits.
// All outputs are registered.

module pdl_puf_eval_ctrl #(
    parameter int RESP_BITS     = 8,
    parameter int NUM_VOTES     = 5,
    parameter int SETTLE_CYCLES = 4,
    parameter int CH_W          = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CH_W-1:0]      challenge_seed,
    output logic [CH_W-1:0]      puf_challenge,
    output logic                 puf_trigger,
    input  logic                 xor_response,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] response
);

    localparam int VOTE_W = $clog2(NUM_VOTES + 1);
    localparam int BIT_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);

    localparam logic [VOTE_W-1:0] LAST_VOTE   = VOTE_W'(NUM_VOTES - 1);
    localparam logic [VOTE_W-1:0] HALF_VOTES  = VOTE_W'(NUM_VOTES / 2);
    localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(RESP_BITS - 1);
    localparam logic [SET_W-1:0]  LAST_SETTLE = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        SETTLE,
        SAMPLE,
        VOTE,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [BIT_W-1:0]  bit_idx;
    logic [VOTE_W-1:0] vote_cnt;
    logic [VOTE_W-1:0] ones_cnt;
    logic [SET_W-1:0]  settle_cnt;

    // State register; reset aborts a run immediately.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode for the launch/settle/sample/vote sequence.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_next
        // unassigned, which would infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LAUNCH;
            LAUNCH:  state_next = SETTLE;
            SETTLE:  if (settle_cnt == LAST_SETTLE) state_next = SAMPLE;
            SAMPLE:  state_next = (vote_cnt < LAST_VOTE) ? LAUNCH : VOTE;
            VOTE:    state_next = (bit_idx == LAST_BIT) ? DONE : LAUNCH;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: challenge, counters and response bits, updated per current state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            puf_challenge <= '0;
            bit_idx       <= '0;
            vote_cnt      <= '0;
            ones_cnt      <= '0;
            settle_cnt    <= '0;
            response      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // response is left alone here; only bits written this run change.
                    if (start) begin
                        puf_challenge <= challenge_seed;
                        bit_idx       <= '0;
                        vote_cnt      <= '0;
                        ones_cnt      <= '0;
                    end
                end
                LAUNCH: begin
                    settle_cnt <= '0;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + SET_W'(1);
                end
                SAMPLE: begin
                    ones_cnt <= ones_cnt + VOTE_W'(xor_response);
                    vote_cnt <= vote_cnt + VOTE_W'(1);
                end
                VOTE: begin
                    response[bit_idx] <= (ones_cnt > HALF_VOTES);
                    vote_cnt          <= '0;
                    ones_cnt          <= '0;
                    if (bit_idx != LAST_BIT) begin
                        bit_idx       <= bit_idx + BIT_W'(1);
                        puf_challenge <= puf_challenge + CH_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Control outputs are registered from the next state.
    // Each one is then high exactly while the FSM sits in the matching state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            puf_trigger <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            puf_trigger <= (state_next == LAUNCH);
            done        <= (state_next == DONE);
            busy        <= (state_next != IDLE);
        end
    end

endmodule
